ecall_input_unit: RTL and testbench

//  Input-side responder for the CPU's read-integer ecall. Complements the SegData display output path.
//  On a request from the EX stage it waits for a debounced press of the confirm button.
//  It then samples the 8 switches and returns them as a 32-bit register-file write value.
//  A one-cycle done pulse releases the pipeline stall/clear logic.

---
 rtl/cpu_io_pkg.sv | 30 +++
 rtl/ecall_input_unit_debounce.sv | 58 +++++
 rtl/ecall_input_unit.sv | 164 ++++++++++++++++
 tb/tb_ecall_input_unit.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_io_pkg.sv
// Shared types and constants for the CPU I/O ecall units.
//   ein_state_t      : state of the read-integer ecall input responder
//   ECALL_READ_INT   : a7 code for a signed integer read
//   ECALL_READ_UINT  : a7 code for an unsigned integer read
// The decode helpers show how the upstream decoder turns a7 into the
// req / req_signed pair that the input unit consumes.
package cpu_io_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REL,
    PRESS,
    DONE,
    DROP
  } ein_state_t;

  localparam int ECALL_READ_INT  = 5;
  localparam int ECALL_READ_UINT = 6;

  // True for either integer-read ecall code.
  function automatic logic is_read_int_code(input logic [31:0] a7);
    return (a7 == 32'(ECALL_READ_INT)) || (a7 == 32'(ECALL_READ_UINT));
  endfunction

  // True when the read result must be sign-extended.
  function automatic logic read_is_signed(input logic [31:0] a7);
    return a7 == 32'(ECALL_READ_INT);
  endfunction

endpackage

// File: rtl/ecall_input_unit_debounce.sv
// btn_debounce: synchronizer, stability counter and rising-edge detector
// for one raw asynchronous push-button.
//   clk        : core clock
//   rst        : asynchronous active-low reset
//   raw        : raw button level, asynchronous
//   level      : debounced level, flips only after the synchronized input
//                has differed from it for DEBOUNCE_CYCLES consecutive cycles
//   rise_pulse : one-cycle pulse coinciding with the first cycle level=1
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 20000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise_pulse
);

  localparam int             CW       = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q;
  logic          level_q;
  logic          rise_q;
  logic [CW-1:0] cnt_q;
  logic          sync_btn;
  logic          flip;

  assign sync_btn = sync_q[1];
  // Last cycle of a full run of disagreement: the level takes the new value.
  assign flip     = (sync_btn != level_q) && (cnt_q == CNT_LAST);

  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q  <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync_q <= {sync_q[0], raw};
      rise_q <= flip && sync_btn;
      if (sync_btn == level_q) begin
        cnt_q <= '0;
      end else if (flip) begin
        cnt_q   <= '0;
        level_q <= sync_btn;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign level      = level_q;
  assign rise_pulse = rise_q;

endmodule

// File: rtl/ecall_input_unit.sv
// ecall_input_unit: responder for the read-integer ecall. On req it waits
// for a fresh debounced press of the confirm button, samples the switches
// and returns them (sign- or zero-extended) as a register-file write value.
//   clk, rst        : core clock, asynchronous active-low reset
//   req, req_signed : ecall request level from EX and its extension mode
//   button          : raw confirm button (active-high, asynchronous)
//   switches        : raw switch bank (asynchronous)
//   busy            : high in every state except IDLE
//   done, wr_en     : one-cycle completion / register write pulse
//   result          : returned value, held until the next completion
//   timeout         : high with done when the wait expired without a press
// Build option: define IO_TIMEOUT_EN to bound the wait by TIMEOUT_CYCLES;
// without it the wait is unbounded and timeout is tied low.
module ecall_input_unit
  import cpu_io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int SW_W            = 8,
  parameter int TIMEOUT_CYCLES  = 2**24
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req,
  input  logic            req_signed,
  input  logic            button,
  input  logic [SW_W-1:0] switches,
  output logic            busy,
  output logic            done,
  output logic            wr_en,
  output logic [31:0]     result,
  output logic            timeout
);

  if (DEBOUNCE_CYCLES < 2 || SW_W < 1 || SW_W > 32 || TIMEOUT_CYCLES < 2) begin : g_bad_params
    $error("ecall_input_unit: parameter out of range");
  end

  ein_state_t      state_q, state_d;
  logic            signed_q, signed_d;
  logic [31:0]     result_q, result_d;
  logic [SW_W-1:0] sw_meta_q, sw_sync_q;
  logic            btn_db;
  logic            press_evt;
  logic            expired;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn_debounce (
    .clk       (clk),
    .rst       (rst),
    .raw       (button),
    .level     (btn_db),
    .rise_pulse(press_evt)
  );

  function automatic logic [31:0] extend(input logic [SW_W-1:0] sw, input logic sgn);
    return sgn ? 32'($signed(sw)) : 32'(sw);
  endfunction

`ifdef IO_TIMEOUT_EN
  localparam int            TW        = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] WAIT_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] wait_q, wait_d;
  logic          to_q, to_d;

  assign expired = (wait_q == WAIT_LAST);
`else
  assign expired = 1'b0;
`endif

  // NOTE: every next-state signal gets a default before the case so each
  // path assigns it and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    signed_d = signed_q;
    result_d = result_q;
`ifdef IO_TIMEOUT_EN
    to_d     = to_q;
    // Zero while idle, so it starts from 0 whichever wait state is entered.
    wait_d   = (state_q == REL || state_q == PRESS) ? wait_q + TW'(1) : '0;
`endif
    case (state_q)
      IDLE: begin
        if (req) begin
          signed_d = req_signed;
`ifdef IO_TIMEOUT_EN
          to_d     = 1'b0;
`endif
          // A press already held when the request arrives must be released first.
          state_d  = btn_db ? REL : PRESS;
        end
      end
      REL: begin
        if (!req) begin
          state_d = IDLE;
        end else if (expired) begin
          result_d = '0;
`ifdef IO_TIMEOUT_EN
          to_d     = 1'b1;
`endif
          state_d  = DONE;
        end else if (!btn_db) begin
          state_d = PRESS;
        end
      end
      PRESS: begin
        if (!req) begin
          state_d = IDLE;
        end else if (press_evt) begin
          result_d = extend(sw_sync_q, signed_q);
          state_d  = DONE;
        end else if (expired) begin
          result_d = '0;
`ifdef IO_TIMEOUT_EN
          to_d     = 1'b1;
`endif
          state_d  = DONE;
        end
      end
      DONE:    state_d = DROP;
      DROP:    if (!req) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      signed_q  <= 1'b0;
      result_q  <= '0;
      sw_meta_q <= '0;
      sw_sync_q <= '0;
    end else begin
      state_q   <= state_d;
      signed_q  <= signed_d;
      result_q  <= result_d;
      sw_meta_q <= switches;
      sw_sync_q <= sw_meta_q;
    end
  end

`ifdef IO_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_q <= '0;
      to_q   <= 1'b0;
    end else begin
      wait_q <= wait_d;
      to_q   <= to_d;
    end
  end

  assign timeout = (state_q == DONE) && to_q;
`else
  assign timeout = 1'b0;
`endif

  assign busy   = (state_q != IDLE);
  assign done   = (state_q == DONE);
  assign wr_en  = (state_q == DONE);
  assign result = result_q;

endmodule

// File: tb/tb_ecall_input_unit.sv
// Self-checking bench for ecall_input_unit: directed scenarios with literal
// expectations plus a randomized phase, all compared every cycle against a
// behavioural model of the request/press/extend protocol.
module tb_ecall_input_unit;

  localparam int DB = 4;
  localparam int TO = 64;
  localparam int SW = 8;
`ifdef IO_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  localparam int P_IDLE  = 0;
  localparam int P_REL   = 1;
  localparam int P_PRESS = 2;
  localparam int P_DONE  = 3;
  localparam int P_DROP  = 4;

  logic          clk        = 1'b0;
  logic          rst        = 1'b1;
  logic          req        = 1'b0;
  logic          req_signed = 1'b0;
  logic          button     = 1'b0;
  logic [SW-1:0] switches   = '0;
  logic          busy, done, wr_en, timeout;
  logic [31:0]   result;

  int          n_checks = 0;
  int          n_errors = 0;
  int          n_done   = 0;
  int          n_wr     = 0;
  logic [31:0] last_res = '0;

  ecall_input_unit #(
    .DEBOUNCE_CYCLES(DB),
    .SW_W           (SW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_signed(req_signed),
    .button    (button),
    .switches  (switches),
    .busy      (busy),
    .done      (done),
    .wr_en     (wr_en),
    .result    (result),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic          m_btn_d [2];     // raw button as seen 1 and 2 edges ago
  logic [SW-1:0] m_sw_d  [2];
  logic          m_db     = 1'b0; // accepted button level
  int            m_run    = 0;    // consecutive cycles sync level disagreed
  logic          m_evt    = 1'b0; // accepted level just became 1
  int            m_phase  = P_IDLE;
  logic          m_signed = 1'b0;
  logic [31:0]   m_result = '0;
  logic          m_to     = 1'b0;
  int            m_wait   = 0;    // cycles already spent waiting for the press

  function automatic logic [31:0] model_value(input logic [SW-1:0] sw, input logic sgn);
    int v;
    v = int'(sw);
    if (sgn && v >= (1 << (SW - 1))) v = v - (1 << SW);
    return 32'(v);
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_btn_d[0] = 1'b0; m_btn_d[1] = 1'b0;
      m_sw_d[0]  = '0;   m_sw_d[1]  = '0;
      m_db = 1'b0; m_run = 0; m_evt = 1'b0;
      m_phase = P_IDLE; m_signed = 1'b0; m_result = '0; m_to = 1'b0; m_wait = 0;
    end else begin
      logic sync_now, new_evt, expire;
      sync_now = m_btn_d[1];
      new_evt  = 1'b0;
      expire   = TO_EN && (m_wait == TO - 1);
      case (m_phase)
        P_IDLE: if (req) begin
          m_signed = req_signed; m_to = 1'b0; m_wait = 0;
          m_phase  = m_db ? P_REL : P_PRESS;
        end
        P_REL: begin
          if (!req) m_phase = P_IDLE;
          else if (expire) begin m_result = '0; m_to = 1'b1; m_phase = P_DONE; end
          else begin
            m_wait++;
            if (!m_db) m_phase = P_PRESS;
          end
        end
        P_PRESS: begin
          if (!req) m_phase = P_IDLE;
          else if (m_evt) begin m_result = model_value(m_sw_d[1], m_signed); m_phase = P_DONE; end
          else if (expire) begin m_result = '0; m_to = 1'b1; m_phase = P_DONE; end
          else m_wait++;
        end
        P_DONE: m_phase = P_DROP;
        default: if (!req) m_phase = P_IDLE;
      endcase
      if (sync_now != m_db) begin
        m_run++;
        if (m_run == DB) begin m_db = sync_now; m_run = 0; new_evt = sync_now; end
      end else begin
        m_run = 0;
      end
      m_evt = new_evt;
      m_btn_d[1] = m_btn_d[0]; m_btn_d[0] = button;
      m_sw_d[1]  = m_sw_d[0];  m_sw_d[0]  = switches;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    check("busy",    32'(busy),    32'(m_phase != P_IDLE));
    check("done",    32'(done),    32'(m_phase == P_DONE));
    check("wr_en",   32'(wr_en),   32'(m_phase == P_DONE));
    check("timeout", 32'(timeout), 32'((m_phase == P_DONE) && m_to));
    check("result",  result,       m_result);
    if (done)  begin n_done++; last_res = result; end
    if (wr_en) n_wr++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic press(input int hold);
    button = 1'b1;
    tick(hold);
    button = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int cycles, output logic seen);
    cycles = 0;
    while (cycles < budget && !done) begin
      tick(1);
      cycles++;
    end
    seen = done;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got running, expected finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   base, base_wr, cyc;
    logic seen;

    // 1. reset values, then reset in the middle of a request
    #1 rst = 1'b0;
    tick(3);
    check("rst_busy",   32'(busy),   32'd0);
    check("rst_done",   32'(done),   32'd0);
    check("rst_result", result,      32'h0);
    rst = 1'b1;
    tick(2);
    check("idle_busy", 32'(busy), 32'd0);
    req = 1'b1;
    tick(2);
    check("req_busy", 32'(busy), 32'd1);
    rst = 1'b0;
    #1;
    check("async_rst_busy",    32'(busy),    32'd0);
    check("async_rst_done",    32'(done),    32'd0);
    check("async_rst_wr_en",   32'(wr_en),   32'd0);
    check("async_rst_timeout", 32'(timeout), 32'd0);
    check("async_rst_result",  result,       32'h0);
    tick(2);
    req = 1'b0;
    rst = 1'b1;
    tick(2);
    check("post_rst_busy", 32'(busy), 32'd0);

    // 2. signed then unsigned read of 8'hF6
    switches = 8'hF6; req_signed = 1'b1; req = 1'b1;
    base = n_done; base_wr = n_wr;
    tick(2);
    press(10);
    tick(2);
    check("t2_signed_done_count", 32'(n_done - base), 32'd1);
    check("t2_signed_wr_count",   32'(n_wr - base_wr), 32'd1);
    check("t2_signed_result",     last_res, 32'hFFFFFFF6);
    req = 1'b0;
    tick(12);
    req_signed = 1'b0; req = 1'b1;
    base = n_done;
    tick(2);
    press(10);
    tick(2);
    check("t2_unsigned_done_count", 32'(n_done - base), 32'd1);
    check("t2_unsigned_result",     last_res, 32'h000000F6);
    req = 1'b0;
    tick(12);

    // 3. press held from before req, then a short glitch
    button = 1'b1;
    tick(10);
    switches = 8'h7F; req_signed = 1'b1; req = 1'b1;
    base = n_done;
    tick(20);
    check("t3_held_no_done", 32'(n_done - base), 32'd0);
    check("t3_held_busy",    32'(busy), 32'd1);
    button = 1'b0;
    tick(10);
    check("t3_release_no_done", 32'(n_done - base), 32'd0);
    press(10);
    tick(2);
    check("t3_fresh_done_count", 32'(n_done - base), 32'd1);
    check("t3_fresh_result",     last_res, 32'h0000007F);
    req = 1'b0;
    tick(12);
    switches = 8'h01; req = 1'b1;
    tick(2);
    base = n_done;
    press(3);
    tick(20);
    check("t3_glitch_no_done", 32'(n_done - base), 32'd0);
    check("t3_glitch_busy",    32'(busy), 32'd1);
    req = 1'b0;
    tick(3);

    // 4. req kept high after done
    switches = 8'h3C; req_signed = 1'b0; req = 1'b1;
    tick(2);
    base = n_done;
    press(10);
    tick(5);
    check("t4_single_done", 32'(n_done - base), 32'd1);
    check("t4_result",      last_res, 32'h0000003C);
    check("t4_busy_held",   32'(busy), 32'd1);
    req = 1'b0;
    tick(2);
    check("t4_busy_clear", 32'(busy), 32'd0);
    tick(8);

    // 5. branch flush while waiting for the press
    switches = 8'h5A; req = 1'b1;
    tick(2);
    base = n_done;
    tick(3);
    req = 1'b0;
    tick(3);
    check("t5_abort_busy",   32'(busy), 32'd0);
    check("t5_abort_done",   32'(n_done - base), 32'd0);
    check("t5_abort_result", result, 32'h0000003C);
    switches = 8'h80; req_signed = 1'b1; req = 1'b1;
    tick(2);
    press(10);
    tick(2);
    check("t5_next_done",   32'(n_done - base), 32'd1);
    check("t5_next_result", last_res, 32'hFFFFFF80);
    req = 1'b0;
    tick(12);

    // 6. no press at all
    switches = 8'h55; req = 1'b1;
    base = n_done;
`ifdef IO_TIMEOUT_EN
    wait_done(100, cyc, seen);
    check("t6_timeout_seen",    32'(seen), 32'd1);
    check("t6_timeout_cycle",   32'(cyc), 32'd65);
    check("t6_timeout_flag",    32'(timeout), 32'd1);
    check("t6_timeout_result",  result, 32'h0);
`else
    tick(1000);
    check("t6_no_done",   32'(n_done - base), 32'd0);
    check("t6_busy_wait", 32'(busy), 32'd1);
    wait_done(1, cyc, seen);
    check("t6_no_done_now", 32'(seen), 32'd0);
`endif
    req = 1'b0;
    tick(3);

    // 7. randomized traffic with one reset in the middle
    for (int i = 0; i < 400; i++) begin
      if (i == 200) begin
        rst = 1'b0;
        tick(3);
        rst = 1'b1;
      end
      case ($urandom_range(0, 4))
        0: begin req = ~req; req_signed = 1'($urandom_range(0, 1)); end
        1, 2: button = ~button;
        3: switches = SW'($urandom);
        default: ;
      endcase
      tick($urandom_range(1, 8));
    end
    req = 1'b0;
    button = 1'b0;
    tick(12);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
